// File: rtl/wb_stage.sv
// Write-back stage: GPR write port with load extension, architectural HI/LO,
// and a minimal CP0 (Count/Compare/Status/Cause/EPC) with timer interrupt.
module wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] wr_dout,
  input  logic [31:0] wr_result,
  input  logic [31:0] wr_HL,
  input  logic [63:0] wr_mult,
  input  logic [31:0] wr_busA_mux2,
  input  logic [31:0] wr_busB_mux2,
  input  logic [4:0]  wr_rw,
  input  logic        wr_regWr,
  input  logic        wr_multWr,
  input  logic        wr_Highin,
  input  logic        wr_Lowin,
  input  logic [1:0]  wr_memtoreg,
  input  logic [5:0]  wr_op,
  input  logic [2:0]  wr_cp0op,
  input  logic [4:0]  wr_cs,
  input  logic [2:0]  wr_sel,
  input  logic [31:0] wr_cp0_dout,
  input  logic [4:0]  cp0_raddr,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] cp0_rdata,
  output logic [31:0] cp0_status,
  output logic [31:0] cp0_cause,
  output logic [31:0] cp0_epc,
  output logic        timer_irq
);

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;

  localparam logic [2:0] CP0OP_MTC0 = 3'd1;
  localparam logic [2:0] CP0OP_ERET = 3'd2;

  localparam logic [4:0] CP0_COUNT   = 5'd9;
  localparam logic [4:0] CP0_COMPARE = 5'd11;
  localparam logic [4:0] CP0_STATUS  = 5'd12;
  localparam logic [4:0] CP0_CAUSE   = 5'd13;
  localparam logic [4:0] CP0_EPC     = 5'd14;

  localparam logic [XLEN-1:0] STATUS_MASK = 32'h0000_FF03;
  localparam logic [XLEN-1:0] CAUSE_MASK  = 32'h0000_0300;

  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  logic            w_mtc0;
  logic            w_eret;
  logic            w_wr_count;
  logic            w_wr_compare;
  logic            w_wr_status;
  logic            w_wr_cause;
  logic            w_wr_epc;
  logic [XLEN-1:0] w_wmask;
  logic [XLEN-1:0] w_wdata_m;
  logic [XLEN-1:0] w_count_nxt;
  logic            w_match;
  logic [XLEN-1:0] w_rd_reg;

  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_count;
  logic [XLEN-1:0] r_compare;
  logic [XLEN-1:0] r_status;
  logic [1:0]      r_cause_sw;
  logic            r_cause_ip7;
  logic [XLEN-1:0] r_epc;

  // Little-endian byte/half pick and extension by opcode
  always_comb begin
    w_byte = 8'h00;
    w_half = 16'h0000;
    w_load = wr_dout;
    case (wr_result[1:0])
      2'd0:    w_byte = wr_dout[7:0];
      2'd1:    w_byte = wr_dout[15:8];
      2'd2:    w_byte = wr_dout[23:16];
      default: w_byte = wr_dout[31:24];
    endcase
    w_half = wr_result[1] ? wr_dout[31:16] : wr_dout[15:0];
    case (wr_op)
      OP_LB:   w_load = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load = {24'h000000, w_byte};
      OP_LH:   w_load = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load = {16'h0000, w_half};
      default: w_load = wr_dout;
    endcase
  end

  always_comb begin
    rf_wdata = wr_result;
    case (wr_memtoreg)
      2'd0:    rf_wdata = wr_result;
      2'd1:    rf_wdata = w_load;
      2'd2:    rf_wdata = wr_HL;
      default: rf_wdata = wr_cp0_dout;
    endcase
  end

  assign rf_we    = wr_regWr & (wr_rw != 5'd0);
  assign rf_waddr = wr_rw;

  // CP0 write decode; selects other than 0 never reach a register
  assign w_mtc0       = (wr_cp0op == CP0OP_MTC0) && (wr_sel == 3'd0);
  assign w_eret       = (wr_cp0op == CP0OP_ERET);
  assign w_wr_count   = w_mtc0 && (wr_cs == CP0_COUNT);
  assign w_wr_compare = w_mtc0 && (wr_cs == CP0_COMPARE);
  assign w_wr_status  = w_mtc0 && (wr_cs == CP0_STATUS);
  assign w_wr_cause   = w_mtc0 && (wr_cs == CP0_CAUSE);
  assign w_wr_epc     = w_mtc0 && (wr_cs == CP0_EPC);

  always_comb begin
    w_wmask = '0;
    case (wr_cs)
      CP0_COUNT, CP0_COMPARE, CP0_EPC: w_wmask = '1;
      CP0_STATUS:                      w_wmask = STATUS_MASK;
      CP0_CAUSE:                       w_wmask = CAUSE_MASK;
      default:                         w_wmask = '0;
    endcase
  end

  assign w_wdata_m   = wr_busB_mux2 & w_wmask;
  // A software write to Count replaces this cycle's increment
  assign w_count_nxt = w_wr_count ? wr_busB_mux2 : r_count + XLEN'(1);
  assign w_match     = (w_count_nxt == r_compare);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (wr_multWr) begin
      r_hi <= wr_mult[63:32];
      r_lo <= wr_mult[31:0];
    end else begin
      if (wr_Highin) r_hi <= wr_busA_mux2;
      if (wr_Lowin)  r_lo <= wr_busA_mux2;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count     <= '0;
      r_compare   <= '1;
      r_status    <= '0;
      r_cause_sw  <= 2'b00;
      r_cause_ip7 <= 1'b0;
      r_epc       <= '0;
    end else begin
      r_count <= w_count_nxt;
      if (w_wr_compare) r_compare <= wr_busB_mux2;
      if (w_wr_status)  r_status <= wr_busB_mux2 & STATUS_MASK;
      else if (w_eret)  r_status[1] <= 1'b0;
      if (w_wr_cause)   r_cause_sw <= wr_busB_mux2[9:8];
      // Compare write acknowledges the timer even on a coincident match
      if (w_wr_compare) r_cause_ip7 <= 1'b0;
      else if (w_match) r_cause_ip7 <= 1'b1;
      if (w_wr_epc)     r_epc <= wr_busB_mux2;
    end
  end

  assign hi         = r_hi;
  assign lo         = r_lo;
  assign cp0_status = r_status;
  assign cp0_cause  = {16'h0000, r_cause_ip7, 5'b00000, r_cause_sw, 8'h00};
  assign cp0_epc    = r_epc;
  assign timer_irq  = r_cause_ip7 & r_status[15] & r_status[0] & ~r_status[1];

  always_comb begin
    w_rd_reg = '0;
    case (cp0_raddr)
      CP0_COUNT:   w_rd_reg = r_count;
      CP0_COMPARE: w_rd_reg = r_compare;
      CP0_STATUS:  w_rd_reg = r_status;
      CP0_CAUSE:   w_rd_reg = cp0_cause;
      CP0_EPC:     w_rd_reg = r_epc;
      default:     w_rd_reg = '0;
    endcase
  end

  assign cp0_rdata = (w_mtc0 && (wr_cs == cp0_raddr)) ? w_wdata_m : w_rd_reg;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: abstract CP0/HI-LO model checked every negedge,
// plus directed literal checks that pin the model.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] wr_dout, wr_result, wr_HL, wr_busA_mux2, wr_busB_mux2, wr_cp0_dout;
  logic [63:0] wr_mult;
  logic [4:0]  wr_rw, wr_cs, cp0_raddr;
  logic        wr_regWr, wr_multWr, wr_Highin, wr_Lowin;
  logic [1:0]  wr_memtoreg;
  logic [5:0]  wr_op;
  logic [2:0]  wr_cp0op, wr_sel;
  logic        rf_we, timer_irq;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, hi, lo, cp0_rdata, cp0_status, cp0_cause, cp0_epc;

  int n_vec = 0;
  int n_err = 0;

  wb_stage dut (
    .clk(clk), .rst_n(rst_n),
    .wr_dout(wr_dout), .wr_result(wr_result), .wr_HL(wr_HL), .wr_mult(wr_mult),
    .wr_busA_mux2(wr_busA_mux2), .wr_busB_mux2(wr_busB_mux2), .wr_rw(wr_rw),
    .wr_regWr(wr_regWr), .wr_multWr(wr_multWr), .wr_Highin(wr_Highin), .wr_Lowin(wr_Lowin),
    .wr_memtoreg(wr_memtoreg), .wr_op(wr_op), .wr_cp0op(wr_cp0op), .wr_cs(wr_cs),
    .wr_sel(wr_sel), .wr_cp0_dout(wr_cp0_dout), .cp0_raddr(cp0_raddr),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .hi(hi), .lo(lo),
    .cp0_rdata(cp0_rdata), .cp0_status(cp0_status), .cp0_cause(cp0_cause),
    .cp0_epc(cp0_epc), .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural model state
  logic [31:0] m_hi, m_lo, m_count, m_compare, m_status, m_cause, m_epc;

  function automatic bit is_mtc0(input int r);
    return (wr_cp0op == 3'd1) && (wr_sel == 3'd0) && (int'(wr_cs) == r);
  endfunction

  function automatic logic [31:0] wmask(input int r);
    case (r)
      9, 11, 14: return 32'hFFFF_FFFF;
      12:        return 32'h0000_FF03;
      13:        return 32'h0000_0300;
      default:   return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] m_next_count();
    return is_mtc0(9) ? wr_busB_mux2 : m_count + 32'd1;
  endfunction

  function automatic logic [31:0] m_next_cause();
    logic [31:0] c;
    c = m_cause;
    if (is_mtc0(13)) c = (c & ~32'h300) | (wr_busB_mux2 & 32'h300);
    if (is_mtc0(11)) c = c & ~32'h8000;
    else if (m_next_count() == m_compare) c = c | 32'h8000;
    return c;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hi <= 0; m_lo <= 0; m_count <= 0; m_compare <= 32'hFFFF_FFFF;
      m_status <= 0; m_cause <= 0; m_epc <= 0;
    end else begin
      if (wr_multWr) begin
        m_hi <= wr_mult[63:32];
        m_lo <= wr_mult[31:0];
      end else begin
        if (wr_Highin) m_hi <= wr_busA_mux2;
        if (wr_Lowin)  m_lo <= wr_busA_mux2;
      end
      m_count <= m_next_count();
      m_cause <= m_next_cause();
      if (is_mtc0(11)) m_compare <= wr_busB_mux2;
      if (is_mtc0(12)) m_status <= wr_busB_mux2 & 32'hFF03;
      else if (wr_cp0op == 3'd2) m_status <= m_status & ~32'h2;
      if (is_mtc0(14)) m_epc <= wr_busB_mux2;
    end
  end

  function automatic logic [31:0] exp_wdata();
    logic [31:0] b, h;
    b = (wr_dout >> (8 * int'(wr_result[1:0]))) & 32'hFF;
    h = (wr_dout >> (16 * int'(wr_result[1]))) & 32'hFFFF;
    case (wr_memtoreg)
      2'd0: return wr_result;
      2'd2: return wr_HL;
      2'd3: return wr_cp0_dout;
      default: case (wr_op)
        6'h20: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
        6'h24: return b;
        6'h21: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
        6'h25: return h;
        default: return wr_dout;
      endcase
    endcase
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (is_mtc0(int'(cp0_raddr))) return wr_busB_mux2 & wmask(int'(cp0_raddr));
    case (cp0_raddr)
      5'd9:  return m_count;
      5'd11: return m_compare;
      5'd12: return m_status;
      5'd13: return m_cause;
      5'd14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("rf_we", rf_we, wr_regWr && (wr_rw != 0));
    chk("rf_waddr", rf_waddr, wr_rw);
    chk("rf_wdata", rf_wdata, exp_wdata());
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("cp0_rdata", cp0_rdata, exp_rdata());
    chk("status", cp0_status, m_status);
    chk("cause", cp0_cause, m_cause);
    chk("epc", cp0_epc, m_epc);
    chk("timer_irq", timer_irq, m_cause[15] & m_status[15] & m_status[0] & ~m_status[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    wr_dout = 0; wr_result = 0; wr_HL = 0; wr_mult = 0; wr_busA_mux2 = 0;
    wr_busB_mux2 = 0; wr_cp0_dout = 0; wr_rw = 0; wr_cs = 0; cp0_raddr = 0;
    wr_regWr = 0; wr_multWr = 0; wr_Highin = 0; wr_Lowin = 0; wr_memtoreg = 0;
    wr_op = 0; wr_cp0op = 0; wr_sel = 0;
  endtask

  task automatic mtc0(input logic [4:0] cs, input logic [31:0] val);
    wr_cp0op = 3'd1; wr_sel = 3'd0; wr_cs = cs; wr_busB_mux2 = val;
    tick();
    wr_cp0op = 3'd0; wr_cs = 5'd0; wr_busB_mux2 = 0;
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    tick();
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_irq", timer_irq, 32'h0);
    cp0_raddr = 5'd9; #1;
    chk("rst_count", cp0_rdata, 32'h0);
    cp0_raddr = 5'd11; #1;
    chk("rst_compare", cp0_rdata, 32'hFFFF_FFFF);
    tick();
    rst_n = 1'b1;

    // Timer: enable IE+IM7, Compare=10, then count up to the match
    mtc0(5'd12, 32'h0000_8001);
    mtc0(5'd11, 32'd10);
    cp0_raddr = 5'd9;
    repeat (7) tick();
    chk("count9", cp0_rdata, 32'd9);
    chk("ip7_pre", cp0_cause[15], 32'h0);
    chk("irq_pre", timer_irq, 32'h0);
    tick();
    chk("count10", cp0_rdata, 32'd10);
    chk("ip7_set", cp0_cause[15], 32'h1);
    chk("irq_set", timer_irq, 32'h1);
    tick();
    chk("ip7_sticky", cp0_cause[15], 32'h1);
    mtc0(5'd11, 32'd100);
    chk("ip7_clr", cp0_cause[15], 32'h0);
    chk("irq_clr", timer_irq, 32'h0);

    // Load extension
    wr_dout = 32'h80FF_7F01; wr_memtoreg = 2'd1; wr_regWr = 1; wr_rw = 5'd3;
    wr_op = 6'h20; wr_result = 32'h3; #1;
    chk("lb_off3", rf_wdata, 32'hFFFF_FF80);
    tick();
    wr_op = 6'h25; wr_result = 32'h0; #1;
    chk("lhu_off0", rf_wdata, 32'h0000_7F01);
    tick();
    wr_op = 6'h21; wr_result = 32'h2; #1;
    chk("lh_off2", rf_wdata, 32'hFFFF_80FF);
    tick();
    wr_op = 6'h24; wr_result = 32'h1; #1;
    chk("lbu_off1", rf_wdata, 32'h0000_007F);
    tick();
    wr_op = 6'h23; #1;
    chk("lw", rf_wdata, 32'h80FF_7F01);
    tick();

    // GPR port
    wr_rw = 5'd0; #1;
    chk("we_r0", rf_we, 32'h0);
    tick();
    wr_rw = 5'd5; wr_memtoreg = 2'd2; wr_HL = 32'h1234; #1;
    chk("we_r5", rf_we, 32'h1);
    chk("wdata_hl", rf_wdata, 32'h1234);
    tick();
    wr_memtoreg = 2'd3; wr_cp0_dout = 32'hCAFE; #1;
    chk("wdata_cp0", rf_wdata, 32'hCAFE);
    tick();
    wr_memtoreg = 2'd0; wr_result = 32'hDEAD_BEEF; #1;
    chk("wdata_alu", rf_wdata, 32'hDEAD_BEEF);
    tick();
    clr();

    // HI/LO
    wr_multWr = 1; wr_mult = 64'h1111_2222_3333_4444; wr_Highin = 1; wr_busA_mux2 = 32'h99;
    tick();
    chk("mult_hi", hi, 32'h1111_2222);
    chk("mult_lo", lo, 32'h3333_4444);
    wr_multWr = 0; wr_Highin = 0; wr_Lowin = 1; wr_busA_mux2 = 32'd7;
    tick();
    chk("mtlo_lo", lo, 32'd7);
    chk("mtlo_hi", hi, 32'h1111_2222);
    wr_Highin = 1; wr_busA_mux2 = 32'd5;
    tick();
    chk("both_hi", hi, 32'd5);
    chk("both_lo", lo, 32'd5);
    wr_Highin = 0; wr_Lowin = 0;

    // EPC write with sel=1 is ignored; sel=0 bypasses to the read port
    cp0_raddr = 5'd14; wr_cp0op = 3'd1; wr_cs = 5'd14; wr_busB_mux2 = 32'hBFC0_0380;
    wr_sel = 3'd1; #1;
    chk("sel1_rd", cp0_rdata, 32'h0);
    tick();
    chk("sel1_epc", cp0_epc, 32'h0);
    wr_sel = 3'd0; #1;
    chk("bypass_rd", cp0_rdata, 32'hBFC0_0380);
    chk("bypass_epc_old", cp0_epc, 32'h0);
    tick();
    chk("epc_new", cp0_epc, 32'hBFC0_0380);
    wr_cp0op = 3'd0;

    // Masks, ERET, unimplemented register
    cp0_raddr = 5'd12;
    mtc0(5'd12, 32'hFFFF_FFFF);
    chk("status_mask", cp0_status, 32'h0000_FF03);
    chk("irq_exl", timer_irq, 32'h0);
    wr_cp0op = 3'd2;
    tick();
    wr_cp0op = 3'd0;
    chk("eret", cp0_status, 32'h0000_FF01);
    mtc0(5'd13, 32'hFFFF_FFFF);
    chk("cause_mask", cp0_cause, 32'h0000_0300);
    cp0_raddr = 5'd3; wr_cp0op = 3'd1; wr_cs = 5'd3; wr_busB_mux2 = 32'h55; #1;
    chk("unimpl_rd", cp0_rdata, 32'h0);
    tick();
    wr_cp0op = 3'd0;

    // Reset mid-run
    cp0_raddr = 5'd9;
    mtc0(5'd9, 32'd57);
    #1;
    chk("count57", cp0_rdata, 32'd57);
    chk("hi5", hi, 32'd5);
    rst_n = 1'b0; #1;
    chk("mid_count", cp0_rdata, 32'h0);
    chk("mid_hi", hi, 32'h0);
    cp0_raddr = 5'd11; #1;
    chk("mid_compare", cp0_rdata, 32'hFFFF_FFFF);
    rst_n = 1'b1;
    cp0_raddr = 5'd9;
    tick();
    chk("post_count1", cp0_rdata, 32'd1);
    tick();
    chk("post_count2", cp0_rdata, 32'd2);

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage of the five-stage MIPS pipeline, directly downstream of the MEM/WB pipeline register. It consumes the `wr_*` bundle and drives the GPR write port. The GPR write data comes from a load-extension and result mux. The block also owns the architectural HI/LO pair and a small CP0 register set (Count, Compare, Status, Cause, EPC) with a timer interrupt.

## Interface
- No parameters.
- `clk`  in  1  pipeline clock; all state updates on rising edge.
- `rst_n`  in  1  one clock; reset is asynchronous and active-low.
- `wr_dout`  in  32  raw memory word read for the instruction.
- `wr_result`  in  32  ALU result; also the load address.
- `wr_HL`  in  32  HI or LO value selected upstream for MFHI/MFLO.
- `wr_mult`  in  64  multiply/divide product {hi,lo}.
- `wr_busA_mux2` / `wr_busB_mux2`  in  32  forwarded rs / rt values.
- `wr_rw`  in  5  GPR destination.
- `wr_regWr` / `wr_multWr` / `wr_Highin` / `wr_Lowin`  in  1  GPR write / HI-LO product write / MTHI / MTLO.
- `wr_memtoreg`  in  2  write-data select.
- `wr_op`  in  6  primary opcode.
- `wr_cp0op`  in  3  CP0 operation.
- `wr_cs`  in  5  CP0 register number.
- `wr_sel`  in  3  CP0 select field.
- `wr_cp0_dout`  in  32  MFC0 data read earlier in the pipe.
- `cp0_raddr`  in  5  CP0 read address from the MEM stage.
- `rf_we`  out  1  GPR write enable.
- `rf_waddr`  out  5  GPR write address.
- `rf_wdata`  out  32  GPR write data.
- `hi` / `lo`  out  32  architectural HI/LO registers.
- `cp0_rdata`  out  32  CP0 read data.
- `cp0_status` / `cp0_cause` / `cp0_epc`  out  32  register values.
- `timer_irq`  out  1  timer interrupt request.

## Operation
- GPR port (combinational)
  - `rf_we` = `wr_regWr` & (`wr_rw`≠0).
  - `rf_waddr` = `wr_rw`.
- `rf_wdata` by `wr_memtoreg`
  - 0: `wr_result`.
  - 1: extended load.
  - 2: `wr_HL`.
  - 3: `wr_cp0_dout`.
- Load extension, little-endian, byte offset = `wr_result[1:0]`
  - 0x20 LB: sign-extended byte.
  - 0x24 LBU: zero-extended byte.
  - 0x21 LH: sign-extended half at `wr_result[1]`.
  - 0x25 LHU: zero-extended half at `wr_result[1]`.
  - 0x23 LW and any other op: full word.
- HI/LO
  - `wr_multWr`: {hi,lo} ← `wr_mult`. Takes priority over MTHI/MTLO.
  - Otherwise `wr_Highin`: hi ← `wr_busA_mux2`.
  - Otherwise `wr_Lowin`: lo ← `wr_busA_mux2`.
  - `wr_Highin` and `wr_Lowin` may both be set; both registers are written.
- CP0 registers
  - Implemented: 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
  - Other numbers read 0; writes to them are ignored.
- `wr_cp0op` encoding
  - 1 MTC0: write `wr_busB_mux2` to `wr_cs`, only when `wr_sel`=0.
  - 2 ERET: clear Status[1] (EXL).
  - All other values: no-op.
- Write masks
  - Count, Compare, EPC: full 32 bits.
  - Status: bits 15:8, 1, 0; other bits read 0.
  - Cause: bits 9:8 only; bit 15 (IP7) is hardware-owned.
- Count/Compare
  - Count increments by 1 every cycle, wrapping 0xFFFFFFFF→0.
  - When the incremented Count equals Compare, Cause[15] is set. It is sticky.
  - Any MTC0 to Compare clears Cause[15].
- `timer_irq` = Cause[15] & Status[15] & Status[0] & ~Status[1].
- `cp0_rdata`
  - Normally returns the registered value at `cp0_raddr`.
  - If a same-cycle MTC0 (sel 0) targets `cp0_raddr`, returns the masked write data (bypass).

## Timing
- GPR outputs are combinational from the `wr_*` inputs, zero latency. The register file captures them at the next edge.
- HI/LO and CP0 updates become visible on outputs the cycle after the edge.
- Reset values (asynchronous, on `rst_n` low):
  - hi = lo = 0.
  - Count = 0, Compare = 0xFFFFFFFF.
  - Status = Cause = EPC = 0, so `timer_irq` = 0.
  - `rf_*` and `cp0_rdata` follow inputs combinationally, even in reset.
- Simultaneous events
  - MTC0 Count versus increment: the written value wins, with no +1 that cycle.
  - MTC0 Compare in the same cycle as a match: clear wins; Cause[15] = 0.
  - MTC0 Status and ERET in the same instruction: impossible; `wr_cp0op` is single-valued.
- Reset asserted mid-operation discards any pending update in that cycle.

## Test plan
- LB and LHU extension
  - `wr_dout`=0x80FF7F01, memtoreg=1, op=0x20, addr[1:0]=3 → `rf_wdata`=0xFFFFFF80.
  - Same word, op=0x25, addr[1]=0 → `rf_wdata`=0x00007F01.
- `wr_regWr`=1, `wr_rw`=0 → `rf_we`=0. With `wr_rw`=5 and memtoreg=2, `wr_HL`=0x1234 → `rf_we`=1, `rf_wdata`=0x1234.
- `wr_multWr`=1, `wr_mult`=0x11112222_33334444, with `wr_Highin`=1 in the same cycle → next cycle hi=0x11112222, lo=0x33334444. Then `wr_Lowin`=1, busA=7 → lo=7, hi unchanged.
- Timer
  - MTC0 Status=0x8001, Compare=10 after reset → Cause[15] and `timer_irq` go to 1 when Count reaches 10.
  - MTC0 Compare=100 → Cause[15]=0 next cycle.
- Read bypass: MTC0 EPC=0xBFC00380 with `cp0_raddr`=14 in the same cycle → `cp0_rdata`=0xBFC00380 that cycle. With `wr_sel`=1 → write ignored, EPC stays 0.
- Reset mid-run
  - Pulse `rst_n` low with Count=57 and hi=5 → Count=0, hi=0, Compare=0xFFFFFFFF immediately, without a clock edge.
  - After release, Count increments once per clock, reaching 1 after the first edge.
